// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the register file and the stages around it.
// Decode and execute stages import the defaults so operand buses stay consistent.
package regfile_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_DEPTH  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_t;

endpackage : regfile_pkg

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks a pointer over every entry, issuing one zero-write per cycle.
// The state register is exported so checkers and the top can observe it directly.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter  int DEPTH  = RF_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              busy,
    output rf_state_t         state
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        ptr   <= '0;
                    end
                end
                CLEAR: begin
                    // Exit decoded from the last index; the pointer wraps to 0 on its own.
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST_ADDR) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    ptr   <= '0;
                end
            endcase
        end
    end

    assign clr_we   = (state == CLEAR);
    assign clr_addr = ptr;
    assign busy     = (state == CLEAR);

endmodule : regfile_clear_seq

// File: rtl/regfile_param.sv
// Parametrised two-read/one-write register file with write bypass, optional
// hardwired-zero entry 0 and a one-entry-per-cycle hardware clear.
module regfile_param
    import regfile_pkg::*;
#(
    parameter  int DATA_W   = RF_DATA_W,
    parameter  int DEPTH    = RF_DEPTH,
    parameter  int ZERO_REG = 0,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              clr_req,
    output logic              busy
);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    rf_state_t         clr_state;

    logic              user_we;
    logic              eff_we;
    logic [ADDR_W-1:0] eff_addr;
    logic [DATA_W-1:0] eff_data;
    logic [DATA_W-1:0] rd_next1;
    logic [DATA_W-1:0] rd_next2;

    regfile_clear_seq #(
        .DEPTH (DEPTH)
    ) u_clear_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .busy     (busy),
        .state    (clr_state)
    );

    // User writes are only honoured in IDLE; a write to the hardwired entry is dropped here.
    always_comb begin
        user_we = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
        if (clr_state == CLEAR) begin
            eff_we   = clr_we;
            eff_addr = clr_addr;
            eff_data = '0;
        end else begin
            eff_we   = user_we;
            eff_addr = wr_addr;
            eff_data = wr_data;
        end
    end

    always_comb begin
        rd_next1 = mem[rd_addr1];
        if (eff_we && (eff_addr == rd_addr1)) begin
            rd_next1 = eff_data;
        end
        if ((ZERO_REG != 0) && (rd_addr1 == '0)) begin
            rd_next1 = '0;
        end

        rd_next2 = mem[rd_addr2];
        if (eff_we && (eff_addr == rd_addr2)) begin
            rd_next2 = eff_data;
        end
        if ((ZERO_REG != 0) && (rd_addr2 == '0)) begin
            rd_next2 = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (eff_we) begin
            mem[eff_addr] <= eff_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data1 <= '0;
            rd_data2 <= '0;
        end else begin
            rd_data1 <= rd_next1;
            rd_data2 <= rd_next2;
        end
    end

endmodule : regfile_param

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param across four configurations sharing one stimulus bus.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
module tb_regfile_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int          sel = 0;
    logic        wr_en = 1'b0;
    logic        clr_req = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [3:0]  rd_addr1 = '0;
    logic [3:0]  rd_addr2 = '0;
    logic [31:0] wr_data = '0;

    logic [31:0] a_rd1, a_rd2, z_rd1, z_rd2, e_rd1, e_rd2;
    logic [7:0]  s_rd1, s_rd2;
    logic        a_busy, z_busy, e_busy, s_busy;

    logic [31:0] rd1, rd2;
    logic        busy;

    int errors = 0;
    int checks = 0;

    // 32x4, plain entry 0
    regfile_param #(.DATA_W(32), .DEPTH(4), .ZERO_REG(0)) u_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en && sel == 0), .wr_addr(wr_addr[1:0]),
        .wr_data(wr_data), .rd_addr1(rd_addr1[1:0]), .rd_addr2(rd_addr2[1:0]),
        .rd_data1(a_rd1), .rd_data2(a_rd2), .clr_req(clr_req && sel == 0), .busy(a_busy)
    );

    // 32x4, hardwired-zero entry 0
    regfile_param #(.DATA_W(32), .DEPTH(4), .ZERO_REG(1)) u_z (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en && sel == 1), .wr_addr(wr_addr[1:0]),
        .wr_data(wr_data), .rd_addr1(rd_addr1[1:0]), .rd_addr2(rd_addr2[1:0]),
        .rd_data1(z_rd1), .rd_data2(z_rd2), .clr_req(clr_req && sel == 1), .busy(z_busy)
    );

    // 32x8
    regfile_param #(.DATA_W(32), .DEPTH(8), .ZERO_REG(0)) u_e (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en && sel == 2), .wr_addr(wr_addr[2:0]),
        .wr_data(wr_data), .rd_addr1(rd_addr1[2:0]), .rd_addr2(rd_addr2[2:0]),
        .rd_data1(e_rd1), .rd_data2(e_rd2), .clr_req(clr_req && sel == 2), .busy(e_busy)
    );

    // 8x16
    regfile_param #(.DATA_W(8), .DEPTH(16), .ZERO_REG(0)) u_s (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en && sel == 3), .wr_addr(wr_addr),
        .wr_data(wr_data[7:0]), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(s_rd1), .rd_data2(s_rd2), .clr_req(clr_req && sel == 3), .busy(s_busy)
    );

    always_comb begin
        rd1  = '0;
        rd2  = '0;
        busy = 1'b0;
        case (sel)
            0:       begin rd1 = a_rd1;          rd2 = a_rd2;          busy = a_busy; end
            1:       begin rd1 = z_rd1;          rd2 = z_rd2;          busy = z_busy; end
            2:       begin rd1 = e_rd1;          rd2 = e_rd2;          busy = e_busy; end
            default: begin rd1 = {24'h0, s_rd1}; rd2 = {24'h0, s_rd2}; busy = s_busy; end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [3:0] addr, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic read(input logic [3:0] a1, input logic [3:0] a2);
        rd_addr1 = a1;
        rd_addr2 = a2;
        tick();
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            write(4'(i), 32'(i + 1));
        end
    endtask

    initial begin
        int cnt;
        logic [31:0] prev;

        // ---- reset ----
        rst_n = 1'b0;
        tick();
        tick();
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #1;
            check($sformatf("rst_busy_%0d", s), {31'h0, busy}, 32'h0);
            check($sformatf("rst_rd1_%0d", s), rd1, 32'h0);
            check($sformatf("rst_rd2_%0d", s), rd2, 32'h0);
        end
        rst_n = 1'b1;
        tick();

        // ---- basic write/read, 32x4 ----
        sel = 0;
        write(4'd2, 32'hDEADBEEF);
        write(4'd3, 32'h12345678);
        read(4'd2, 4'd3);
        check("rd_e2", rd1, 32'hDEADBEEF);
        check("rd_e3", rd2, 32'h12345678);

        // same-cycle bypass
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'hA5A5A5A5;
        rd_addr1 = 4'd1; rd_addr2 = 4'd0;
        tick();
        wr_en = 1'b0;
        check("bypass_rd1", rd1, 32'hA5A5A5A5);
        check("bypass_rd2_e0", rd2, 32'h0);
        read(4'd1, 4'd2);
        check("array_e1", rd1, 32'hA5A5A5A5);
        check("array_e2_kept", rd2, 32'hDEADBEEF);

        // entry 0 is ordinary storage without ZERO_REG
        write(4'd0, 32'h00000011);
        read(4'd0, 4'd3);
        check("plain_e0", rd1, 32'h00000011);
        check("plain_e3", rd2, 32'h12345678);

        // ---- hardwired zero entry ----
        sel = 1;
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hFFFFFFFF;
        rd_addr1 = 4'd0; rd_addr2 = 4'd0;
        tick();
        wr_en = 1'b0;
        check("zr_bypass_rd1", rd1, 32'h0);
        check("zr_bypass_rd2", rd2, 32'h0);
        read(4'd0, 4'd0);
        check("zr_array_rd1", rd1, 32'h0);
        check("zr_array_rd2", rd2, 32'h0);
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'h00000077;
        rd_addr1 = 4'd1; rd_addr2 = 4'd0;
        tick();
        wr_en = 1'b0;
        check("zr_e1_bypass", rd1, 32'h00000077);
        check("zr_e0_alt", rd2, 32'h0);

        // ---- clear sequence, 32x8 ----
        sel = 2;
        fill(8);
        read(4'd0, 4'd7);
        check("fill_e0", rd1, 32'd1);
        check("fill_e7", rd2, 32'd8);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        check("clr_busy_rise", {31'h0, busy}, 32'h1);
        cnt = 1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (cyc == 3) begin
                rd_addr1 = 4'd2; rd_addr2 = 4'd5;
                wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h55;
            end
            if (cyc == 4) begin
                wr_en = 1'b0;
                clr_req = 1'b1;
            end
            if (cyc == 5) begin
                clr_req = 1'b0;
                wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'h66;
            end
            if (cyc == 6) wr_en = 1'b0;
            tick();
            if (cyc == 3) begin
                check("clr_ptr_bypass", rd1, 32'h0);
                check("clr_above_ptr", rd2, 32'd6);
            end
            if (busy) cnt++;
            else break;
        end
        wr_en = 1'b0;
        clr_req = 1'b0;
        check("clr_busy_cycles", 32'(cnt), 32'd8);
        write(4'd4, 32'h99);
        read(4'd4, 4'd7);
        check("post_clr_write", rd1, 32'h99);
        check("post_clr_e7", rd2, 32'h0);
        for (int i = 0; i < 8; i++) begin
            read(4'(i), 4'(7 - i));
            check($sformatf("clr_e%0d", i), rd1, (i == 4) ? 32'h99 : 32'h0);
        end

        // ---- reset in the middle of a clear ----
        fill(8);
        rd_addr1 = 4'd6; rd_addr2 = 4'd7;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        tick();
        tick();
        check("pre_rst_rd1", rd1, 32'd7);
        rst_n = 1'b0;
        #2;
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check("mid_rst_rd1", rd1, 32'h0);
        check("mid_rst_rd2", rd2, 32'h0);
        #2;
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", {31'h0, busy}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            read(4'(i), 4'(i));
            check($sformatf("rst_e%0d", i), rd1, 32'h0);
        end
        write(4'd5, 32'h42);
        read(4'd5, 4'd5);
        check("rst_then_write", rd2, 32'h42);

        // ---- 8x16: write racing a clear request ----
        sel = 3;
        write(4'd15, 32'hFF);
        read(4'd15, 4'd15);
        check("s_e15_ff", rd1, 32'hFF);
        clr_req = 1'b1;
        wr_en = 1'b1; wr_addr = 4'd15; wr_data = 32'h0F;
        rd_addr1 = 4'd15;
        tick();
        clr_req = 1'b0;
        wr_en = 1'b0;
        check("s_race_bypass", rd1, 32'h0F);
        check("s_race_busy", {31'h0, busy}, 32'h1);
        cnt = 1;
        prev = rd1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            tick();
            if (busy) begin
                cnt++;
                prev = rd1;
            end else begin
                break;
            end
        end
        check("s_busy_cycles", 32'(cnt), 32'd16);
        check("s_e15_before_last", prev, 32'h0F);
        check("s_e15_cleared", rd1, 32'h0);
        read(4'd15, 4'd0);
        check("s_e15_array", rd1, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_regfile_param
